// File: rtl/wvb_rd_pkg.sv
// Shared types and constants for the waveform buffer reader: FSM states, header field
// placement and the end-of-event flag position inside a stored word.
package wvb_rd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StHdr,
    StRead,
    StFlush
  } state_e;

  // Header address fields are packed back to back from bit 0, one address width each.
  localparam int unsigned HdrStartField = 0;
  localparam int unsigned HdrStopField  = 1;

  localparam int unsigned EoeBit = 0;

  function automatic int unsigned hdr_field_lsb(input int unsigned field,
                                                input int unsigned adr_w);
    return field * adr_w;
  endfunction

endpackage

// File: rtl/wvb_rd_skid.sv
// Two-entry output skid buffer (data + last) with valid/ready on both sides; the level output
// lets the producer account for reads still in flight.
module wvb_rd_skid #(
  parameter int unsigned Width = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       level
);

  logic [Width:0] mem_q [2];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     cnt_q;
  logic           push;
  logic           pop;

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  // A full buffer may still accept when the head leaves in the same cycle.
  assign in_ready  = (cnt_q != 2'd2) || out_ready;
  assign push      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {in_data, in_last};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_data = mem_q[rd_ptr_q][Width:1];
  assign out_last = out_valid && mem_q[rd_ptr_q][0];
  assign level    = cnt_q;

endmodule

// File: rtl/waveform_buffer_reader.sv
// Pops event headers, streams the addressed waveform samples through a skid buffer.
// Optional eoe/stop-address consistency check enabled by defining WVB_RD_EOE_CHECK_EN.
module waveform_buffer_reader
  import wvb_rd_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_ADR_WIDTH  = 12,
  parameter int unsigned P_HDR_WIDTH  = 80
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data_in,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data_in,
  output logic [P_HDR_WIDTH-1:0]  hdr_out,
  output logic                    hdr_out_valid,
  input  logic                    hdr_out_ready,
  output logic [P_DATA_WIDTH-2:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic                    eoe_err
);

  localparam int unsigned StartLsb = hdr_field_lsb(HdrStartField, P_ADR_WIDTH);
  localparam int unsigned StopLsb  = hdr_field_lsb(HdrStopField, P_ADR_WIDTH);

  state_e                   state_q, state_d;
  logic                     armed_q;
  logic [P_HDR_WIDTH-1:0]   hdr_q, hdr_d;
  logic [P_ADR_WIDTH-1:0]   addr_q, addr_d;
  logic [P_ADR_WIDTH-1:0]   stop_q, stop_d;
  logic                     pend_q, pend_d;
  logic                     pend_last_q, pend_last_d;
  logic [1:0]               skid_level;
  logic                     skid_in_ready;
  logic                     xfer_last;
  logic                     room;

  assign xfer_last = dout_valid && dout_ready && dout_last;
  // Buffered + in-flight samples after this cycle's pop must leave a slot for a new read.
  assign room = ({1'b0, skid_level} + {2'b00, pend_q}) < (3'd2 + {2'b00, dout_valid && dout_ready});

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    addr_d      = addr_q;
    stop_d      = stop_q;
    pend_d      = 1'b0;
    pend_last_d = 1'b0;
    hdr_rdreq   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // armed_q keeps the pop strobe low while reset is asserted.
        if (en && !hdr_empty && armed_q) begin
          hdr_rdreq = 1'b1;
          state_d   = StPop;
        end
      end
      StPop: begin
        hdr_d   = hdr_data_in;
        addr_d  = hdr_data_in[StartLsb +: P_ADR_WIDTH];
        stop_d  = hdr_data_in[StopLsb +: P_ADR_WIDTH];
        state_d = StHdr;
      end
      StHdr: begin
        if (hdr_out_ready) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (room && skid_in_ready) begin
          pend_d      = 1'b1;
          pend_last_d = (addr_q == stop_q);
          if (addr_q == stop_q) begin
            state_d = StFlush;
          end else begin
            addr_d = addr_q + P_ADR_WIDTH'(1);
          end
        end
      end
      StFlush: begin
        if (xfer_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      hdr_q       <= '0;
      addr_q      <= '0;
      stop_q      <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= 1'b1;
      hdr_q       <= hdr_d;
      addr_q      <= addr_d;
      stop_q      <= stop_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  wvb_rd_skid #(
    .Width(P_DATA_WIDTH - 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (wvb_data_in[P_DATA_WIDTH-1:1]),
    .in_last  (pend_last_q),
    .in_valid (pend_q),
    .in_ready (skid_in_ready),
    .out_data (dout),
    .out_last (dout_last),
    .out_valid(dout_valid),
    .out_ready(dout_ready),
    .level    (skid_level)
  );

  assign hdr_out       = hdr_q;
  assign hdr_out_valid = (state_q == StHdr);
  assign wvb_rd_addr   = addr_q;
  assign busy          = (state_q != StIdle);

`ifdef WVB_RD_EOE_CHECK_EN
  logic eoe_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoe_err_q <= 1'b0;
    end else if (pend_q && (wvb_data_in[EoeBit] != pend_last_q)) begin
      eoe_err_q <= 1'b1;
    end
  end

  assign eoe_err = eoe_err_q;
`else
  logic unused_eoe;
  assign unused_eoe = wvb_data_in[EoeBit];
  assign eoe_err    = 1'b0;
`endif

endmodule

// File: tb/tb_waveform_buffer_reader.sv
// Scoreboard bench for waveform_buffer_reader: a header FIFO and a 1-cycle RAM model feed the
// DUT; expected headers/samples are queued at stimulus time and checked by a negedge monitor.
module tb_waveform_buffer_reader;

  localparam int unsigned DW = 22;
  localparam int unsigned AW = 12;
  localparam int unsigned HW = 80;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          hdr_empty;
  logic [HW-1:0] hdr_data_in = '0;
  logic          hdr_rdreq;
  logic [AW-1:0] wvb_rd_addr;
  logic [DW-1:0] wvb_data_in = '0;
  logic [HW-1:0] hdr_out;
  logic          hdr_out_valid;
  logic          hdr_out_ready;
  logic [DW-2:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          dout_last;
  logic          busy;
  logic          eoe_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram [4096];
  logic [HW-1:0] hdr_store [64];
  int            hdr_push = 0;
  int            hdr_pop = 0;
  int            pop_while_empty = 0;
  logic [DW-1:0] exp_q [$];
  logic [HW-1:0] exp_hdr_q [$];
  int            cyc = 0;
  int            xfer_cnt = 0;
  int            xfer_cyc [1024];
  bit            rand_ready = 1'b0;

  waveform_buffer_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .hdr_empty    (hdr_empty),
    .hdr_data_in  (hdr_data_in),
    .hdr_rdreq    (hdr_rdreq),
    .wvb_rd_addr  (wvb_rd_addr),
    .wvb_data_in  (wvb_data_in),
    .hdr_out      (hdr_out),
    .hdr_out_valid(hdr_out_valid),
    .hdr_out_ready(hdr_out_ready),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout_last    (dout_last),
    .busy         (busy),
    .eoe_err      (eoe_err)
  );

  always #5 clk = ~clk;

  assign hdr_empty = (hdr_push == hdr_pop);

  function automatic void check(input string name, input logic [HW-1:0] act,
                                input logic [HW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Header FIFO (standard read) and waveform RAM (1-cycle read) models.
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    wvb_data_in <= ram[wvb_rd_addr];
    if (hdr_rdreq) begin
      if (hdr_empty) begin
        pop_while_empty <= pop_while_empty + 1;
      end else begin
        hdr_data_in <= hdr_store[hdr_pop % 64];
        hdr_pop     <= hdr_pop + 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compares every header and sample handshake against the scoreboard queues.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_val = '0;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    logic [HW-1:0] eh;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_under_backpressure", {dout_valid, dout, dout_last}, {1'b1, stall_val});
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0h expected none", {dout, dout_last});
        end else begin
          e = exp_q.pop_front();
          check("sample", {dout, dout_last}, e);
        end
        xfer_cyc[xfer_cnt % 1024] = cyc;
        xfer_cnt++;
      end
      stall_prev = dout_valid && !dout_ready;
      stall_val  = {dout, dout_last};
      if (hdr_out_valid && hdr_out_ready) begin
        if (exp_hdr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_header: got %0h expected none", hdr_out);
        end else begin
          eh = exp_hdr_q.pop_front();
          check("header", hdr_out, eh);
        end
      end
    end
  end

  // Fills RAM for one event, queues its header and the expected {sample, last} stream.
  task automatic load_event(input logic [AW-1:0] start, input logic [AW-1:0] stop,
                            input logic [7:0] tag, input int plant);
    logic [AW-1:0] a;
    logic [AW-1:0] d;
    logic [HW-1:0] h;
    d = stop - start;
    a = start;
    for (int i = 0; i <= int'(d); i++) begin
      ram[a] = {tag, 1'b0, a, (a == stop)};
      if (plant >= 0 && a == AW'(plant)) ram[a][0] = 1'b1;
      exp_q.push_back({tag, 1'b0, a, (a == stop)});
      a = a + 1'b1;
    end
    h = {tag, 48'hA5A5_1234_5678, stop, start};
    hdr_store[hdr_push % 64] = h;
    exp_hdr_q.push_back(h);
    hdr_push++;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !hdr_empty || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: timeout got %0d samples outstanding expected 0", name, exp_q.size());
    end
    check_int({name, "_hdr_drained"}, exp_hdr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_hdr_rdreq"}, hdr_rdreq, 0);
    check({name, "_hdr_out_valid"}, hdr_out_valid, 0);
    check({name, "_dout_valid"}, dout_valid, 0);
    check({name, "_dout_last"}, dout_last, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_eoe_err"}, eoe_err, 0);
    check({name, "_hdr_out"}, hdr_out, 0);
    check({name, "_dout"}, dout, 0);
    check({name, "_wvb_rd_addr"}, wvb_rd_addr, 0);
  endtask

  initial begin
    int n0;
    int p0;
    int seen;
    int n;
    logic exp_eoe;
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    rst_n         = 1'b0;
    en            = 1'b0;
    hdr_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    en    = 1'b1;

    // Basic event, full throughput.
    n0 = xfer_cnt;
    load_event(12'h010, 12'h013, 8'h11, -1);
    wait_done("basic", 200);
    check_int("basic_count", xfer_cnt - n0, 4);
    check_int("basic_span", xfer_cyc[n0 + 3] - xfer_cyc[n0], 3);
    check("basic_busy_after", busy, 0);

    // Address wrap.
    n0 = xfer_cnt;
    load_event(12'hFFE, 12'h001, 8'h22, -1);
    wait_done("wrap", 200);
    check_int("wrap_count", xfer_cnt - n0, 4);
    check_int("wrap_span", xfer_cyc[n0 + 3] - xfer_cyc[n0], 3);

    // Start == stop.
    n0 = xfer_cnt;
    load_event(12'h0A0, 12'h0A0, 8'h33, -1);
    wait_done("single", 200);
    check_int("single_count", xfer_cnt - n0, 1);

    // Random backpressure over 64 samples; en dropped mid-event must not abort it.
    rand_ready = 1'b1;
    n0 = xfer_cnt;
    load_event(12'h200, 12'h23F, 8'h44, -1);
    n = 0;
    while (!busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    en = 1'b0;
    p0 = hdr_pop;
    wait_done("backpressure", 2000);
    check_int("backpressure_count", xfer_cnt - n0, 64);
    check_int("en_low_no_pop", hdr_pop, p0);
    rand_ready = 1'b0;
    en = 1'b1;

    // Empty FIFO must never be popped; then two queued headers run back to back.
    seen = 0;
    p0 = hdr_pop;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (hdr_rdreq) seen++;
    end
    check_int("empty_rdreq_seen", seen, 0);
    check_int("empty_pop_count", hdr_pop - p0, 0);
    n0 = xfer_cnt;
    p0 = hdr_pop;
    load_event(12'h300, 12'h302, 8'h55, -1);
    load_event(12'h400, 12'h404, 8'h66, -1);
    wait_done("two_headers", 300);
    check_int("two_headers_pops", hdr_pop - p0, 2);
    check_int("two_headers_count", xfer_cnt - n0, 8);
    check_int("pop_while_empty", pop_while_empty, 0);

    // eoe planted one sample before stop.
    check("eoe_clean_before", eoe_err, 0);
`ifdef WVB_RD_EOE_CHECK_EN
    exp_eoe = 1'b1;
`else
    exp_eoe = 1'b0;
`endif
    load_event(12'h010, 12'h013, 8'h77, 32'h011);
    wait_done("eoe", 200);
    check("eoe_err_after", eoe_err, exp_eoe);
    repeat (5) @(posedge clk);
    #1;
    check("eoe_err_sticky", eoe_err, exp_eoe);

    // Reset in the middle of a READ discards the event.
    n0 = xfer_cnt;
    load_event(12'h100, 12'h13F, 8'h88, -1);
    n = 0;
    while (xfer_cnt < n0 + 5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_int("midreset_reached_read", (xfer_cnt >= n0 + 5) ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_hdr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = xfer_cnt;
    load_event(12'h020, 12'h022, 8'h99, -1);
    wait_done("after_reset", 200);
    check_int("after_reset_count", xfer_cnt - n0, 3);
    check("after_reset_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/waveform_buffer_reader.md
WAVEFORM_BUFFER_READER -- requirements
Module: waveform_buffer_reader

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 22, stored word width; bit 0 is the end-of-event (eoe) flag.
REQ-002 SHALL have parameter P_ADR_WIDTH, default 12, waveform buffer address width.
REQ-003 SHALL have parameter P_HDR_WIDTH, default 80, header FIFO word width.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  readout enable; sampled only in IDLE.
REQ-007 hdr_empty  in  1  header FIFO empty.
REQ-008 hdr_data_in  in  P_HDR_WIDTH  header FIFO data; standard (non-FWFT) read, valid 1 cycle after hdr_rdreq.
REQ-009 hdr_rdreq  out  1  header FIFO pop strobe.
REQ-010 wvb_rd_addr  out  P_ADR_WIDTH  waveform buffer read address.
REQ-011 wvb_data_in  in  P_DATA_WIDTH  waveform buffer data; valid 1 cycle after wvb_rd_addr.
REQ-012 hdr_out  out  P_HDR_WIDTH  captured header.
REQ-013 hdr_out_valid / hdr_out_ready  out/in  1  header handshake.
REQ-014 dout  out  P_DATA_WIDTH-1  sample, i.e. wvb_data_in[P_DATA_WIDTH-1:1].
REQ-015 dout_valid / dout_ready  out/in  1  sample handshake; transfer when both high.
REQ-016 dout_last  out  1  qualifies final sample of an event.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 eoe_err  out  1  sticky eoe/stop-address mismatch flag.

Function
REQ-019 Header layout SHALL be: start_addr = hdr[P_ADR_WIDTH-1:0], stop_addr = hdr[2*P_ADR_WIDTH-1:P_ADR_WIDTH]; remaining bits opaque, passed unchanged.
REQ-020 FSM states SHALL be IDLE, POP, HDR, READ, FLUSH.
REQ-021 IDLE: when en && !hdr_empty, assert hdr_rdreq for exactly one cycle -> POP; never pop while hdr_empty.
REQ-022 POP: capture hdr_data_in into hdr_out and load start/stop addresses -> HDR.
REQ-023 HDR: hold hdr_out_valid until hdr_out_ready; on handshake -> READ with wvb_rd_addr = start_addr.
REQ-024 READ: issue one address per cycle while the 2-entry output skid has room; address increments modulo 2^P_ADR_WIDTH (0xFFF -> 0x000 at default width).
REQ-025 After issuing stop_addr, SHALL issue no further addresses -> FLUSH.
REQ-026 FLUSH: drain skid; -> IDLE on the cycle dout_last transfers.
REQ-027 Sample count per event SHALL equal ((stop_addr - start_addr) mod 2^P_ADR_WIDTH) + 1; start == stop yields one sample.
REQ-028 dout_last SHALL be high only with the sample read from stop_addr.
REQ-029 Under backpressure no sample SHALL be dropped, duplicated or reordered; dout/dout_last held stable while dout_valid && !dout_ready.
REQ-030 Throughput SHALL be 1 sample/cycle with dout_ready held high.
REQ-031 Deasserting en mid-event SHALL NOT abort the event; it only blocks the next pop.

Reset
REQ-032 On rst_n low, asynchronously: state = IDLE, hdr_rdreq, hdr_out_valid, dout_valid, dout_last, busy, eoe_err = 0; hdr_out, dout, wvb_rd_addr = 0; skid emptied.
REQ-033 Reset mid-event SHALL discard the event; an already-popped header is lost, no recovery.

Configuration
REQ-034 With WVB_RD_EOE_CHECK_EN defined: eoe_err SHALL set when a sample has eoe=1 at an address other than stop_addr, or eoe=0 at stop_addr; it clears only on reset; readout continues unchanged.
REQ-035 Without WVB_RD_EOE_CHECK_EN: eoe_err SHALL be tied 0 and no check logic synthesized.

Structure
REQ-036 Package wvb_rd_pkg SHALL hold the FSM state enum, header field offsets, and EOE bit index.
REQ-037 The 2-entry output skid buffer SHALL be sub-module wvb_rd_skid (data+last, valid/ready both sides).

Verification
REQ-038 start=0x010, stop=0x013, dout_ready=1 -> 4 samples from 0x010..0x013 on consecutive cycles, dout_last on 4th only, busy low after.
REQ-039 start=0xFFE, stop=0x001 -> addresses 0xFFE, 0xFFF, 0x000, 0x001 read, 4 samples, last on 0x001.
REQ-040 dout_ready random 50% over a 64-sample event -> output equals RAM contents in order, exactly 64 transfers.
REQ-041 hdr_empty=1, en=1 for 100 cycles -> hdr_rdreq never asserted; two queued headers -> exactly two pops, events back-to-back in order.
REQ-042 With WVB_RD_EOE_CHECK_EN, eoe=1 planted at 0x011 of the 0x010..0x013 event -> eoe_err rises on that sample and stays high; without macro -> eoe_err stays 0.
REQ-043 rst_n pulsed low during READ -> all outputs at reset values immediately; next header read cleanly after release.
